// File: rtl/rabbit_pkg.sv
// Shared types and widths for the Rabbit stream controller.
// No logic; no latency.
// No flow control; types only.
package rabbit_pkg;

  localparam int KEY_W = 128;
  localparam int BLK_W = 128;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SETUP = 3'd2,
    PRIME = 3'd3,
    RUN   = 3'd4
  } state_t;

endpackage

// File: rtl/rabbit_stream_ctrl.sv
// Sequences the Rabbit core (load, key setup, prime) and XORs each data block with one keystream word.
// Latency: one cycle from in handshake to out_valid; key setup costs LOAD + setup cycles + one PRIME cycle.
// Backpressure: one-entry output register; in_ready = !out_valid || out_ready, core advances only on an accepted block.
module rabbit_stream_ctrl
  import rabbit_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int SETUP_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] key,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] blk_count,
  output logic             err_timeout,
  output logic             core_load,
  output logic             core_en,
  output logic [KEY_W-1:0] core_key,
  input  logic [BLK_W-1:0] core_keystream,
  input  logic             core_ready
);

  localparam int TMO_W = $clog2(SETUP_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SETUP_TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             key_hs;
  logic             in_hs;
  logic             out_hs;

  assign key_hs = key_valid && key_ready;
  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;
  assign busy   = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and core/handshake strobes; key_ready is held low while reset is asserted.
  always_comb begin
    state_nxt = state;
    key_ready = 1'b0;
    in_ready  = 1'b0;
    core_load = 1'b0;
    core_en   = 1'b0;
    tmo_hit   = 1'b0;
    unique case (state)
      IDLE: begin
        key_ready = rst_n && !out_valid;
      end
      LOAD: begin
        core_load = 1'b1;
        state_nxt = SETUP;
      end
      SETUP: begin
        if (core_ready) begin
          state_nxt = PRIME;
        end else begin
          core_en = 1'b1;
          if (tmo_cnt == TMO_LAST) begin
            tmo_hit   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      PRIME: begin
        // Discard the post-setup state so the first block uses a fresh word.
        core_en   = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        // A held final block stops intake until it leaves; the core is then spent.
        in_ready  = !(out_valid && out_last) && (!out_valid || out_ready);
        key_ready = rst_n && !out_valid && !in_valid;
        core_en   = in_valid && in_ready;
        if (out_valid && out_last && out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (key_valid && key_ready) begin
      state_nxt = LOAD;
    end
  end

  // Key register, setup timeout counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_key    <= '0;
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (key_hs) begin
        core_key    <= key;
        err_timeout <= 1'b0;
      end else if (tmo_hit) begin
        err_timeout <= 1'b1;
      end
      if (state == LOAD) begin
        tmo_cnt <= '0;
      end else if (state == SETUP && !core_ready) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end
  end

  // Output register and block counter; keystream is consumed only on an accepted block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      blk_count <= '0;
    end else begin
      if (key_hs) begin
        blk_count <= '0;
      end
      if (in_hs) begin
        out_data  <= in_data ^ core_keystream;
        out_last  <= in_last;
        out_valid <= 1'b1;
        blk_count <= blk_count + CNT_W'(1);
      end else if (out_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
